// File: rtl/sonar_pkg.sv
// rtl/sonar_pkg.sv - shared FSM codes, ASCII constants and timing default for the sonar UART transmitter
package sonar_pkg;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_LOAD   = 4'd1;
    localparam logic [3:0] ST_START  = 4'd2;
    localparam logic [3:0] ST_DATA   = 4'd3;
    localparam logic [3:0] ST_PARITY = 4'd4;
    localparam logic [3:0] ST_STOP   = 4'd5;
    localparam logic [3:0] ST_NEXT   = 4'd6;
    localparam logic [3:0] ST_DONE   = 4'd7;

    localparam logic [7:0] ASCII_ZERO      = 8'h30;
    localparam logic [7:0] ASCII_BAD_DIGIT = 8'h2A;

    // 50 MHz system clock at 115200 baud
    localparam int BIT_TICKS_DEFAULT = 434;

endpackage

// File: rtl/sonar_tx_ascii_if.sv
// rtl/sonar_tx_ascii_if.sv - start/capture/completion handshake between sonar control unit and transmitter
interface sonar_tx_ascii_if;

    logic        transmitir;
    logic [11:0] angulo;
    logic [11:0] distancia;
    logic        ocupado;
    logic        fim_transmissao;

    modport master (
        output transmitir,
        output angulo,
        output distancia,
        input  ocupado,
        input  fim_transmissao
    );

    modport slave (
        input  transmitir,
        input  angulo,
        input  distancia,
        output ocupado,
        output fim_transmissao
    );

endinterface

// File: rtl/sonar_tx_ascii_bcd.sv
// rtl/sonar_tx_ascii_bcd.sv - combinational BCD nibble to ASCII digit, non-decimal nibbles become '*'
module bcd_to_ascii
    import sonar_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] ascii
);

    assign ascii = (digit > 4'd9) ? ASCII_BAD_DIGIT : (ASCII_ZERO + {4'd0, digit});

endmodule

// File: rtl/sonar_tx_ascii.sv
// rtl/sonar_tx_ascii.sv - serialises a captured angle/distance pair as "AAA,DDD#" over UART
// SONAR_TX_PARITY_EN selects 7O1 framing instead of 8N1; frame timing is identical in both.
module sonar_tx_ascii
    import sonar_pkg::*;
#(
    parameter int         BIT_TICKS = BIT_TICKS_DEFAULT,
    parameter logic [7:0] SEP_CHAR  = 8'h2C,
    parameter logic [7:0] END_CHAR  = 8'h23
) (
    input  logic                clock,
    input  logic                reset,
    sonar_tx_ascii_if.slave     bus,
    output logic                saida_serial,
    output logic [3:0]          db_estado
);

    localparam int TW = $clog2(BIT_TICKS);
    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
`ifdef SONAR_TX_PARITY_EN
    localparam logic [2:0] BIT_LAST      = 3'd6;
    localparam logic [3:0] ST_AFTER_DATA = ST_PARITY;
`else
    localparam logic [2:0] BIT_LAST      = 3'd7;
    localparam logic [3:0] ST_AFTER_DATA = ST_STOP;
`endif

    logic [3:0]    state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    char_q, char_d;
    logic [11:0]   ang_q, ang_d;
    logic [11:0]   dist_q, dist_d;

    logic       in_bit, tick_last;
    logic [2:0] sel_idx;
    logic [3:0] sel_digit;
    logic [7:0] digit_ascii, sel_char;

    // LOAD always picks character 0; NEXT picks the one after the current index
    assign sel_idx = (state_q == ST_LOAD) ? 3'd0 : (idx_q + 3'd1);

    always_comb begin
        sel_digit = 4'd0;
        case (sel_idx)
            3'd0:    sel_digit = ang_q[11:8];
            3'd1:    sel_digit = ang_q[7:4];
            3'd2:    sel_digit = ang_q[3:0];
            3'd4:    sel_digit = dist_q[11:8];
            3'd5:    sel_digit = dist_q[7:4];
            3'd6:    sel_digit = dist_q[3:0];
            default: sel_digit = 4'd0;
        endcase
    end

    bcd_to_ascii u_digit (
        .digit (sel_digit),
        .ascii (digit_ascii)
    );

    assign sel_char = (sel_idx == 3'd3) ? SEP_CHAR :
                      (sel_idx == 3'd7) ? END_CHAR : digit_ascii;

    assign in_bit    = (state_q == ST_START) || (state_q == ST_DATA) ||
                       (state_q == ST_PARITY) || (state_q == ST_STOP);
    assign tick_last = (tick_q == TICK_LAST);

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        char_d  = char_q;
        ang_d   = ang_q;
        dist_d  = dist_q;
        tick_d  = (in_bit && !tick_last) ? (tick_q + 1'b1) : '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.transmitir) begin
                    ang_d   = bus.angulo;
                    dist_d  = bus.distancia;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                idx_d   = 3'd0;
                char_d  = sel_char;
                state_d = ST_START;
            end
            ST_START: begin
                if (tick_last) begin
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick_last) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_AFTER_DATA;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick_last) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (tick_last) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (idx_q == 3'd7) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    char_d  = sel_char;
                    state_d = ST_START;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= 3'd0;
            idx_q   <= 3'd0;
            char_q  <= 8'd0;
            ang_q   <= 12'd0;
            dist_q  <= 12'd0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            char_q  <= char_d;
            ang_q   <= ang_d;
            dist_q  <= dist_d;
        end
    end

    // Line level decodes straight from state so an async reset forces idle-high at once
    always_comb begin
        saida_serial = 1'b1;
        case (state_q)
            ST_START:  saida_serial = 1'b0;
            ST_DATA:   saida_serial = char_q[bit_q];
            ST_PARITY: saida_serial = ~^char_q[6:0];
            default:   saida_serial = 1'b1;
        endcase
    end

    assign bus.ocupado         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign bus.fim_transmissao = (state_q == ST_DONE);
    assign db_estado           = state_q;

endmodule

// File: tb/tb_sonar_tx_ascii.sv
// tb/tb_sonar_tx_ascii.sv - directed bench decoding the UART line into ASCII frames
module tb_sonar_tx_ascii;

    localparam int BT = 4;
    // cycles from the accepting cycle to the DONE cycle; the frame spans FRAME_LAT+1 cycles
    localparam int FRAME_LAT = 2 + 8 * (10 * BT + 1);

    logic       clock = 1'b0;
    logic       reset;
    logic       saida_serial;
    logic [3:0] db_estado;

    sonar_tx_ascii_if bus ();

    sonar_tx_ascii #(.BIT_TICKS(BT)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .saida_serial (saida_serial),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int fim_cnt  = 0;
    bit mon_busy = 0;
    bit busy_drop = 0;
    bit line_low = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        cyc++;
        if (bus.fim_transmissao === 1'b1) begin
            fim_cnt++;
            mon_busy = 0;
        end
        if (mon_busy && bus.ocupado !== 1'b1) busy_drop = 1;
        if (saida_serial !== 1'b1) line_low = 1;
    endtask

    function automatic logic [7:0] expc(input logic [7:0] c);
`ifdef SONAR_TX_PARITY_EN
        return {1'b0, c[6:0]};
`else
        return c;
`endif
    endfunction

    task automatic start_frame(input logic [11:0] a, input logic [11:0] d, output int c0);
        bus.angulo     = a;
        bus.distancia  = d;
        bus.transmitir = 1'b1;
        c0 = cyc;
        step();
        bus.transmitir = 1'b0;
        chk("load_state", db_estado, 4'd1);
        chk("load_busy", bus.ocupado, 1);
        chk("load_line", saida_serial, 1);
        mon_busy  = 1;
        busy_drop = 0;
        fim_cnt   = 0;
        step();
        chk("start_state", db_estado, 4'd2);
        chk("start_bit_latency", saida_serial, 0);
    endtask

    task automatic recv_char(output logic [7:0] ch, output logic par);
        int waited = 0;
        logic [7:0] bits = 8'd0;
        while (saida_serial !== 1'b0 && waited < 200) begin
            step();
            waited++;
        end
        chk("start_timeout", (waited < 200), 1);
        step();
        chk("start_mid", saida_serial, 0);
        for (int j = 0; j < 8; j++) begin
            repeat (BT) step();
            bits[j] = saida_serial;
        end
        repeat (BT) step();
        chk("stop_bit", saida_serial, 1);
`ifdef SONAR_TX_PARITY_EN
        ch  = {1'b0, bits[6:0]};
        par = bits[7];
        chk("odd_parity", par, ~^bits[6:0]);
`else
        ch  = bits;
        par = 1'b0;
`endif
    endtask

    task automatic recv_frame(input logic [63:0] exp, input int c0, input bit inject, output logic p0);
        logic [63:0] e;
        logic [7:0]  ch;
        logic        par;
        int          n = 0;
        e  = exp;
        p0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (inject && i == 3) begin
                bus.angulo     = 12'h999;
                bus.distancia  = 12'h999;
                bus.transmitir = 1'b1;
                step();
                bus.transmitir = 1'b0;
            end
            recv_char(ch, par);
            if (i == 0) p0 = par;
            chk($sformatf("char%0d", i), ch, expc(e[63-8*i -: 8]));
        end
        while (bus.fim_transmissao !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("fim_timeout", (n < 100), 1);
        chk("frame_latency", cyc - c0, FRAME_LAT);
        chk("busy_held", busy_drop, 0);
        chk("done_not_busy", bus.ocupado, 0);
        chk("done_state", db_estado, 4'd7);
    endtask

    initial begin
        int         c0;
        logic       p0;
        logic [7:0] ch;
        logic       par;
        int         n;

        reset          = 1'b0;
        bus.transmitir = 1'b0;
        bus.angulo     = 12'd0;
        bus.distancia  = 12'd0;
        step();
        step();
        chk("rst_line", saida_serial, 1);
        chk("rst_busy", bus.ocupado, 0);
        chk("rst_fim", bus.fim_transmissao, 0);
        chk("rst_state", db_estado, 4'd0);
        reset = 1'b1;
        step();

        // nominal frame with a rejected mid-frame start request
        start_frame(12'h045, 12'h123, c0);
        recv_frame("045,123#", c0, 1'b1, p0);
        step();
        chk("fim_one_cycle", bus.fim_transmissao, 0);
        line_low = 0;
        repeat (400) step();
        chk("no_second_frame", line_low, 0);
        chk("single_fim", fim_cnt, 1);

        // invalid BCD digits, then a start held across DONE and the following cycle
        start_frame(12'h0A9, 12'hF00, c0);
        recv_frame("0*9,*00#", c0, 1'b0, p0);
        bus.angulo     = 12'h180;
        bus.distancia  = 12'h907;
        bus.transmitir = 1'b1;
        step();
        chk("done_start_ignored", bus.ocupado, 0);
        chk("idle_after_done", db_estado, 4'd0);
        start_frame(12'h180, 12'h907, c0);
        recv_frame("180,907#", c0, 1'b0, p0);
`ifdef SONAR_TX_PARITY_EN
        chk("parity_char0", p0, 0);
`endif
        step();

        // reset during DATA of char 2, then a fresh frame
        start_frame(12'h789, 12'h456, c0);
        recv_char(ch, par);
        chk("rst_pre_char0", ch, expc(8'h37));
        recv_char(ch, par);
        chk("rst_pre_char1", ch, expc(8'h38));
        n = 0;
        while (saida_serial !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        chk("char2_timeout", (n < 100), 1);
        repeat (10) step();
        chk("mid_data_state", db_estado, 4'd3);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_line", saida_serial, 1);
        chk("async_rst_busy", bus.ocupado, 0);
        chk("async_rst_state", db_estado, 4'd0);
        chk("async_rst_fim", bus.fim_transmissao, 0);
        mon_busy = 0;
        step();
        reset = 1'b1;
        step();
        chk("post_rst_line", saida_serial, 1);
        start_frame(12'h999, 12'h000, c0);
        recv_frame("999,000#", c0, 1'b0, p0);
        step();
        chk("final_idle", db_estado, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
